// File: rtl/key_cond_if.sv
// Raw key/switch inputs and conditioned event outputs of key_cond.
// The master drives the raw inputs and receives the events; key_cond is the slave.
interface key_cond_if;
  logic       key_plus_n;
  logic       key_sub_n;
  logic [1:0] key_state_raw;
  logic       plus_pulse;
  logic       sub_pulse;
  logic [1:0] key_state;
  logic       state_chg;

  modport master (
    output key_plus_n, key_sub_n, key_state_raw,
    input  plus_pulse, sub_pulse, key_state, state_chg
  );

  modport slave (
    input  key_plus_n, key_sub_n, key_state_raw,
    output plus_pulse, sub_pulse, key_state, state_chg
  );
endinterface

// File: rtl/key_cond.sv
// Key conditioner: synchronizes and debounces two buttons and two mode switches and
// generates press / auto-repeat pulses. Auto-repeat exists only with `define KEY_AUTOREPEAT_EN.
//
// Button FSM
//   state  | meaning
//   IDLE   | button released, waiting for a debounced press
//   HELD   | pressed, press pulse issued, hold counter timing the first repeat
//   REPEAT | auto-repeating, repeat counter timing each further pulse
module key_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000
) (
  input  logic      clk,
  input  logic      rst_n,
  key_cond_if.slave bus
);

  localparam int unsigned DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // channel order: 0 plus, 1 sub, 2/3 mode switch bits; buttons idle high
  localparam logic [3:0]  RST_LVL = 4'b0011;

  if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0 ||
      REPEAT_DELAY > (1 << 24) || REPEAT_PERIOD > (1 << 24)) begin : g_cfg_check
    $error("key_cond: timing parameters must be in 1..2^24");
  end

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} btn_state_t;
  localparam logic [23:0] HOLD_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] REP_LAST  = 24'(REPEAT_PERIOD - 1);
  logic [23:0] hold_cnt [2];
  logic [23:0] rep_cnt  [2];
  logic        both_down;
`else
  typedef enum logic [1:0] {IDLE, HELD} btn_state_t;
`endif

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [3:0]    deb_nxt;
  logic [3:0]    accept;
  logic [DW-1:0] db_cnt [4];
  logic [1:0]    press_evt;
  logic [1:0]    pulse_req;
  btn_state_t    btn_st [2];
  logic          plus_q;
  logic          sub_q;
  logic          chg_q;

  assign raw = {bus.key_state_raw, bus.key_sub_n, bus.key_plus_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_LVL;
      sync2 <= RST_LVL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Acceptance is decoded combinationally so the FSM and state_chg react on the
  // same edge the debounced level flips, keeping latency at DEBOUNCE_CYCLES+2.
  always_comb begin
    accept  = '0;
    deb_nxt = deb;
    for (int i = 0; i < 4; i++) begin
      accept[i]  = (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST);
      deb_nxt[i] = accept[i] ? sync2[i] : deb[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= RST_LVL;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      deb <= deb_nxt;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i] || accept[i]) db_cnt[i] <= '0;
        else                                 db_cnt[i] <= db_cnt[i] + DW'(1);
      end
    end
  end

  assign press_evt = deb[1:0] & ~deb_nxt[1:0];
`ifdef KEY_AUTOREPEAT_EN
  assign both_down = ~deb_nxt[0] & ~deb_nxt[1];
`endif

  always_comb begin
    pulse_req = '0;
    for (int b = 0; b < 2; b++) begin
      case (btn_st[b])
        IDLE:    pulse_req[b] = press_evt[b];
`ifdef KEY_AUTOREPEAT_EN
        HELD:    pulse_req[b] = !deb_nxt[b] && !both_down && (hold_cnt[b] == HOLD_LAST);
        REPEAT:  pulse_req[b] = !deb_nxt[b] && !both_down && (rep_cnt[b] == REP_LAST);
`endif
        default: pulse_req[b] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        btn_st[b] <= IDLE;
`ifdef KEY_AUTOREPEAT_EN
        hold_cnt[b] <= '0;
        rep_cnt[b]  <= '0;
`endif
      end
      plus_q <= 1'b0;
      sub_q  <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        case (btn_st[b])
          IDLE: begin
            if (press_evt[b]) begin
              btn_st[b] <= HELD;
`ifdef KEY_AUTOREPEAT_EN
              hold_cnt[b] <= '0;
`endif
            end
          end
          HELD: begin
            if (deb_nxt[b]) begin
              btn_st[b] <= IDLE;
`ifdef KEY_AUTOREPEAT_EN
              hold_cnt[b] <= '0;
            end else if (both_down) begin
              hold_cnt[b] <= '0;
            end else if (hold_cnt[b] == HOLD_LAST) begin
              btn_st[b]  <= REPEAT;
              rep_cnt[b] <= '0;
            end else begin
              hold_cnt[b] <= hold_cnt[b] + 24'd1;
`endif
            end
          end
`ifdef KEY_AUTOREPEAT_EN
          REPEAT: begin
            if (deb_nxt[b]) begin
              btn_st[b]  <= IDLE;
              rep_cnt[b] <= '0;
            end else if (both_down) begin
              // chord pressed: fall back to HELD so repeating stops
              btn_st[b]   <= HELD;
              hold_cnt[b] <= '0;
            end else if (rep_cnt[b] == REP_LAST) begin
              rep_cnt[b] <= '0;
            end else begin
              rep_cnt[b] <= rep_cnt[b] + 24'd1;
            end
          end
`endif
          default: btn_st[b] <= IDLE;
        endcase
      end
      // simultaneous requests cancel each other; FSMs advance regardless
      plus_q <= pulse_req[0] & ~pulse_req[1];
      sub_q  <= pulse_req[1] & ~pulse_req[0];
      chg_q  <= (deb_nxt[3:2] != deb[3:2]);
    end
  end

  assign bus.plus_pulse = plus_q;
  assign bus.sub_pulse  = sub_q;
  assign bus.state_chg  = chg_q;
  assign bus.key_state  = deb[3:2];

endmodule

// File: doc/key_cond.md
KEY_COND -- requirements
Module: key_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, is the number of consecutive stable clk cycles required to accept a level change (20 ms at 12 MHz).
REQ-002 Parameter REPEAT_DELAY, default 6000000, is the number of clk cycles a button is held before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 1200000, is the number of clk cycles between subsequent auto-repeat pulses.
REQ-004 Port clk, input, 1 bit: the single system clock (12 MHz); all logic is on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port key_plus_n, input, 1 bit: raw "plus" button, active-low, asynchronous to clk.
REQ-007 Port key_sub_n, input, 1 bit: raw "sub" button, active-low, asynchronous to clk.
REQ-008 Port key_state_raw, input, 2 bits: raw mode switches, asynchronous to clk.
REQ-009 Port plus_pulse, output, 1 bit: one-cycle pulse for each accepted "plus" event.
REQ-010 Port sub_pulse, output, 1 bit: one-cycle pulse for each accepted "sub" event.
REQ-011 Port key_state, output, 2 bits: debounced mode, where 00 = run, 01 = night, 10 = set RG, 11 = set Y.
REQ-012 Port state_chg, output, 1 bit: one-cycle pulse when key_state changes.

Function
REQ-013 Each of the 4 raw inputs (2 buttons, 2 switch bits) SHALL pass through its own 2-flop synchronizer before any other use.
REQ-014 Each synchronized input SHALL have a debounced level and a counter; the counter resets to 0 on any cycle where the synchronized value equals the debounced level.
REQ-015 On other cycles the counter SHALL increment; when it reaches DEBOUNCE_CYCLES-1 and the input still differs, the debounced level SHALL take the input value on the next edge and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change; total latency from a clean raw edge to the output SHALL be DEBOUNCE_CYCLES+2 cycles.
REQ-017 Each button SHALL run an FSM with states IDLE, HELD and REPEAT.
- IDLE -> HELD on the debounced press edge (1 to 0); the pulse is asserted in the same cycle.
- HELD -> REPEAT when the hold counter reaches REPEAT_DELAY-1; one pulse is emitted.
- In REPEAT, one pulse is emitted every REPEAT_PERIOD cycles.
- Any state -> IDLE on debounced release; no pulse is emitted on release.
REQ-018 The hold and repeat counters SHALL be 24 bits wide, SHALL clear on every state entry, and SHALL never wrap while a button is held.
REQ-019 If plus_pulse and sub_pulse would assert in the same cycle, both SHALL be suppressed for that cycle; the FSMs still advance.
REQ-020 While both buttons are debounced-pressed, both FSMs SHALL remain in HELD or return to HELD, so no auto-repeat occurs; press pulses already issued are unaffected.
REQ-021 key_state SHALL update both bits in the same cycle; each bit is taken from its own debounced level.
REQ-022 state_chg SHALL pulse for exactly one cycle, coincident with any change of key_state.
REQ-023 All outputs SHALL be registered; pulses SHALL never exceed 1 cycle and SHALL never be back-to-back unless REPEAT_PERIOD = 1.

Reset
REQ-024 Asserting rst_n low SHALL immediately set:
- button synchronizers and debounced levels to 1 (released);
- switch synchronizers and debounced levels to 0;
- all counters to 0 and both FSMs to IDLE;
- plus_pulse, sub_pulse and state_chg to 0, and key_state to 00.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard all progress; after release, a still-pressed button SHALL produce its press pulse DEBOUNCE_CYCLES+2 cycles later.

Configuration
REQ-026 The macro KEY_AUTOREPEAT_EN SHALL control auto-repeat.
- Defined: the REPEAT state and the hold and repeat counters are implemented as in REQ-017.
- Undefined: the FSM is IDLE/HELD only, exactly one pulse is produced per press, and the repeat counters are not synthesized.

Verification
REQ-027 All scenarios below use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
REQ-028 Scenario: key_plus_n held low from cycle 10 -> a single plus_pulse at cycle 16, and sub_pulse stays 0.
REQ-029 Scenario: key_sub_n low for 3 cycles, high for 2, repeated 5 times -> no sub_pulse.
REQ-030 Scenario: KEY_AUTOREPEAT_EN defined, key_plus_n held low for 60 cycles from cycle 0 -> plus_pulse at cycles 6, 26, 34, 42, 50, 58, and none after release.
REQ-031 Scenario: the same test with KEY_AUTOREPEAT_EN undefined -> plus_pulse only at cycle 6.
REQ-032 Scenario: both buttons pressed in the same cycle -> no pulses and no repeats while both are held.
REQ-033 Scenario: key_state_raw changed 00 -> 10, with rst_n pulsed low for 1 cycle at 3 cycles in -> key_state = 10 and state_chg = 1 at 6 cycles after rst_n is released, and nothing is emitted before that.
